// File: rtl/proc_pkg.sv
// Shared processor definitions: default widths and the fetch FSM state encoding.
package proc_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int INS_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  // True while an instruction is in flight (FETCH, LOAD or EXEC).
  function automatic logic is_busy(input fetch_state_e st);
    logic res;
    case (st)
      ST_FETCH: res = 1'b1;
      ST_LOAD:  res = 1'b1;
      ST_EXEC:  res = 1'b1;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: clear to zero, load a jump target, or increment with wrap.
module fetch_pc
  import proc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_zero,
  input  logic              load_jump,
  input  logic              inc,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;

  // Next PC select; zero-load beats jump beats increment, increment wraps naturally.
  always_comb begin
    pc_next_s = pc_r;
    if (load_zero) begin
      pc_next_s = '0;
    end else if (load_jump) begin
      pc_next_s = jump_addr;
    end else if (inc) begin
      pc_next_s = pc_r + PC_ONE;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= '0;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives IRAM reads and the MBRU load strobe,
// then waits for the core to finish before moving the PC on.
module fetch_ctrl
  import proc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INS_W  = INS_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              exec_done,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] iram_addr,
  output logic              iram_en,
  output logic              fetch,
  output logic              ins_valid,
  output logic              busy,
  output logic              halted
);

  if (INS_W < 1) begin : g_ins_w_check
    $error("fetch_ctrl: INS_W must be at least 1");
  end

  fetch_state_e state_r;
  fetch_state_e state_next_s;

  logic load_zero_s;
  logic load_jump_s;
  logic inc_s;

  logic fetch_r;
  logic ins_valid_r;
  logic busy_r;
  logic halted_r;

  logic [ADDR_W-1:0] pc_s;

  fetch_pc #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_zero (load_zero_s),
    .load_jump (load_jump_s),
    .inc       (inc_s),
    .jump_addr (jump_addr),
    .pc        (pc_s)
  );

  // Next-state and PC-update decode; inputs other than start/stall only matter in EXEC.
  always_comb begin
    state_next_s = state_r;
    load_zero_s  = 1'b0;
    load_jump_s  = 1'b0;
    inc_s        = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_next_s = ST_FETCH;
          load_zero_s  = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_FETCH: begin
        if (stall) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_next_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (!exec_done) begin
          state_next_s = ST_EXEC;
        end else if (halt_req) begin
          state_next_s = ST_HALT;
        end else if (jump) begin
          state_next_s = ST_FETCH;
          load_jump_s  = 1'b1;
        end else begin
          state_next_s = ST_FETCH;
          inc_s        = 1'b1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset returns to IDLE from anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Moore outputs registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_r     <= 1'b0;
      ins_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      fetch_r     <= (state_next_s == ST_LOAD);
      ins_valid_r <= (state_next_s == ST_EXEC) && (state_r != ST_EXEC);
      busy_r      <= is_busy(state_next_s);
      halted_r    <= (state_next_s == ST_HALT);
    end
  end

  // The read enable drops in the same cycle stall is raised so a held-off read never issues.
  assign iram_en   = (state_r == ST_FETCH) && !stall;
  assign iram_addr = pc_s;
  assign fetch     = fetch_r;
  assign ins_valid = ins_valid_r;
  assign busy      = busy_r;
  assign halted    = halted_r;

endmodule
